mips_regfile_mp: RTL
====================

Name: mips_regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read MIPS32 register bank.
- Configurable word width, depth, read-port count and write-port count.
- Adds deterministic write-port priority, optional hardwired-zero register $0, optional write-to-read bypass, registered read outputs, and a multi-cycle sweep-clear engine with a BUSY flag.
- Sits between the ID-stage operand fetch and WB-stage writeback; its 2-write configuration serves dual-issue or load/ALU merged writeback.

Parameters:
- WORD_LEN, 32, data width in bits.
- ADDR_LEN, 5, register address width; DEPTH = 2**ADDR_LEN registers.
- NUM_READ, 2, number of read ports (1..4).
- NUM_WRITE, 2, number of write ports (1..3).
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to that read port's output.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- READ_ADDR  input  NUM_READ*ADDR_LEN  packed read addresses; port j occupies bits [j*ADDR_LEN +: ADDR_LEN].
- READ_DATA  output  NUM_READ*WORD_LEN  registered read data, packed likewise.
- WRITE_ENABLE  input  NUM_WRITE  per-port write strobe.
- WRITE_ADDR  input  NUM_WRITE*ADDR_LEN  packed write addresses.
- WRITE_DATA  input  NUM_WRITE*WORD_LEN  packed write data.
- CLEAR_REQ  input  1  single-cycle request to zero the whole bank.
- BUSY  output  1  high while a clear sweep is in progress.

Behaviour:
- Reset:
  - RESET low asynchronously zeroes all DEPTH registers and all READ_DATA.
  - BUSY=0, state=IDLE, sweep counter=0.
  - Release is sampled on the next rising edge.
- Write (IDLE only), at the rising edge:
  - Each port k with WRITE_ENABLE[k]=1 updates REGISTER[WRITE_ADDR_k].
  - If two or more ports target the same address, the highest-index port wins; lower ports to that address are discarded.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Read:
  - Latency is 1 cycle: READ_DATA_j is loaded at the rising edge and holds until the next edge.
  - BYPASS=1: value is REGISTER[READ_ADDR_j] after this edge's writes are applied, i.e. the winning same-edge write data is forwarded.
  - BYPASS=0: value is the pre-edge contents.
  - With ZERO_REG=1, address 0 always yields 0, including when bypassing.
- State machine: IDLE, CLEAR.
  - IDLE → CLEAR: CLEAR_REQ=1 at the edge. BUSY=1 from that edge; counter=0.
  - CLEAR: each edge zeroes REGISTER[counter] and increments counter.
  - CLEAR → IDLE: on the edge that clears index DEPTH-1. BUSY=0 from that edge.
  - BUSY is therefore high for exactly DEPTH cycles.
  - In CLEAR, all writes are dropped, READ_DATA is loaded with 0, and CLEAR_REQ is ignored.
  - A CLEAR_REQ coinciding with writes in IDLE: the writes land at that edge and are zeroed during the sweep.
- Reset asserted mid-sweep: immediate return to IDLE, BUSY=0, all registers zero.
- Counter width is ADDR_LEN+1 so the terminal compare needs no wrap-around.
- No X propagation: out-of-range addresses cannot occur because DEPTH=2**ADDR_LEN.

Test Plan:
- Reset then bypass: RESET low 2 cycles, release; write port0 addr 5 = 0xDEADBEEF while READ_ADDR port0=5 in the same cycle → READ_DATA port0 = 0xDEADBEEF one cycle later (BYPASS=1); with BYPASS=0 it reads 0, then 0xDEADBEEF the following cycle.
- Write conflict: port0 writes addr 7 = 0x11111111 and port1 writes addr 7 = 0x22222222 on the same edge → subsequent read of 7 = 0x22222222.
- Zero register: write addr 0 = 0xFFFFFFFF with ZERO_REG=1 → read of 0 = 0, bypass path included; with ZERO_REG=0 → reads 0xFFFFFFFF.
- Clear sweep: fill all 32 registers with their index+1, pulse CLEAR_REQ → BUSY high exactly 32 cycles and READ_DATA=0 throughout; a write to addr 3 = 0xABCD during BUSY is dropped; after BUSY falls every register reads 0.
- Reset mid-sweep: assert RESET asynchronously at sweep cycle 10, between clock edges → BUSY falls without waiting for an edge; after release, a write to addr 9 = 0x55 reads back 0x55 with 1-cycle latency.
- Multi-port read: NUM_READ=4, addresses 1, 2, 3, 1 after writing 0xA, 0xB, 0xC → outputs 0xA, 0xB, 0xC, 0xA on the same cycle.

Source files
------------

// File: rtl/mips_regfile_mp_if.sv
// Bus bundle for the multi-port MIPS register bank: packed read/write ports,
// clear request and sweep status.
interface mips_regfile_mp_if #(
    parameter int WORD_LEN  = 32,
    parameter int ADDR_LEN  = 5,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2
);
    logic [NUM_READ*ADDR_LEN-1:0]  READ_ADDR;
    logic [NUM_READ*WORD_LEN-1:0]  READ_DATA;
    logic [NUM_WRITE-1:0]          WRITE_ENABLE;
    logic [NUM_WRITE*ADDR_LEN-1:0] WRITE_ADDR;
    logic [NUM_WRITE*WORD_LEN-1:0] WRITE_DATA;
    logic                          CLEAR_REQ;
    logic                          BUSY;

    modport master (
        output READ_ADDR,
        output WRITE_ENABLE,
        output WRITE_ADDR,
        output WRITE_DATA,
        output CLEAR_REQ,
        input  READ_DATA,
        input  BUSY
    );

    modport slave (
        input  READ_ADDR,
        input  WRITE_ENABLE,
        input  WRITE_ADDR,
        input  WRITE_DATA,
        input  CLEAR_REQ,
        output READ_DATA,
        output BUSY
    );
endinterface

// File: rtl/mips_regfile_mp.sv
// Parametrised multi-read/multi-write MIPS register bank with priority writes,
// optional $0, optional write-to-read bypass, registered reads and a sweep clear.
module mips_regfile_mp #(
    parameter int WORD_LEN  = 32,
    parameter int ADDR_LEN  = 5,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter bit ZERO_REG  = 1'b1,
    parameter bit BYPASS    = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    mips_regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_LEN;
    localparam int CNT_W = ADDR_LEN + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_LEN-1:0]  mem_q [DEPTH];
    logic [WORD_LEN-1:0]  mem_d [DEPTH];
    logic [WORD_LEN-1:0]  rd_q  [NUM_READ];
    logic [WORD_LEN-1:0]  rd_d  [NUM_READ];

    logic [ADDR_LEN-1:0]  ra [NUM_READ];
    logic [ADDR_LEN-1:0]  wa [NUM_WRITE];
    logic [WORD_LEN-1:0]  wd [NUM_WRITE];
    logic [NUM_READ*WORD_LEN-1:0] rd_packed;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_rd_unpack
            assign ra[gi] = bus.READ_ADDR[gi*ADDR_LEN +: ADDR_LEN];
        end
        for (gi = 0; gi < NUM_WRITE; gi++) begin : g_wr_unpack
            assign wa[gi] = bus.WRITE_ADDR[gi*ADDR_LEN +: ADDR_LEN];
            assign wd[gi] = bus.WRITE_DATA[gi*WORD_LEN +: WORD_LEN];
        end
    endgenerate

    // Next bank contents and sweep FSM. Ports are applied in ascending order so
    // the highest-index port to a shared address overwrites the lower ones.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        case (state_q)
            ST_IDLE: begin
                for (int k = 0; k < NUM_WRITE; k++) begin
                    if (bus.WRITE_ENABLE[k] && !(ZERO_REG && (wa[k] == '0))) begin
                        mem_d[wa[k]] = wd[k];
                    end
                end
                if (bus.CLEAR_REQ) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                mem_d[cnt_q[ADDR_LEN-1:0]] = '0;
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Read outputs are forced to zero on every edge that starts, continues or
    // ends a sweep, so READ_DATA is zero for the whole time BUSY is high.
    always_comb begin
        for (int j = 0; j < NUM_READ; j++) begin
            rd_d[j] = '0;
            if ((state_q == ST_CLEAR) || (state_d == ST_CLEAR)) begin
                rd_d[j] = '0;
            end else if (ZERO_REG && (ra[j] == '0)) begin
                rd_d[j] = '0;
            end else if (BYPASS) begin
                rd_d[j] = mem_d[ra[j]];
            end else begin
                rd_d[j] = mem_q[ra[j]];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int j = 0; j < NUM_READ; j++) begin
                rd_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            for (int j = 0; j < NUM_READ; j++) begin
                rd_q[j] <= rd_d[j];
            end
        end
    end

    always_comb begin
        rd_packed = '0;
        for (int j = 0; j < NUM_READ; j++) begin
            rd_packed[j*WORD_LEN +: WORD_LEN] = rd_q[j];
        end
    end

    assign bus.READ_DATA = rd_packed;
    assign bus.BUSY      = (state_q == ST_CLEAR);

endmodule
